// File: rtl/uart_tx_fsm_ser.sv
// UART TX control stage: captures a word, serializes it LSB first, and sequences
// the frame (start, data, optional parity, stop) through MUX_SEL. Optional macro: UART_TX_TWO_STOP_EN.
module uart_tx_fsm_ser #(
    parameter int DATA_WIDTH = 8
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic [DATA_WIDTH-1:0] P_DATA,
    input  logic                  DATA_VALID,
    input  logic                  PAR_EN,
    input  logic                  PAR_TYP,
    output logic [1:0]            MUX_SEL,
    output logic                  SER_DATA,
    output logic                  PAR_BIT,
    output logic                  BUSY
);

    localparam int CW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
    localparam logic [CW-1:0] LAST = CW'(DATA_WIDTH - 1);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
`ifdef UART_TX_TWO_STOP_EN
        , STOP2
`endif
    } state_t;

    state_t                state_q, state_d;
    logic [DATA_WIDTH-1:0] shift_q, shift_d;
    logic [CW-1:0]         cnt_q, cnt_d;
    logic                  par_en_q, par_en_d;
    logic                  par_bit_q, par_bit_d;
    logic                  accept;

    // New words are only taken while the line idles at the (final) stop level.
`ifdef UART_TX_TWO_STOP_EN
    assign accept = DATA_VALID && ((state_q == IDLE) || (state_q == STOP2));
`else
    assign accept = DATA_VALID && ((state_q == IDLE) || (state_q == STOP));
`endif

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (accept) state_d = START;
            START:   state_d = DATA;
            DATA:    if (cnt_q == LAST) state_d = par_en_q ? PARITY : STOP;
            PARITY:  state_d = STOP;
`ifdef UART_TX_TWO_STOP_EN
            STOP:    state_d = STOP2;
            STOP2:   state_d = accept ? START : IDLE;
`else
            STOP:    state_d = accept ? START : IDLE;
`endif
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        MUX_SEL = 2'b01;
        case (state_q)
            START:   MUX_SEL = 2'b00;
            DATA:    MUX_SEL = 2'b10;
            PARITY:  MUX_SEL = 2'b11;
            default: MUX_SEL = 2'b01;
        endcase
        BUSY     = (state_q != IDLE);
        SER_DATA = shift_q[0];
        PAR_BIT  = par_bit_q;
    end

    always_comb begin
        shift_d   = shift_q;
        cnt_d     = cnt_q;
        par_en_d  = par_en_q;
        par_bit_d = par_bit_q;
        if (accept) begin
            shift_d   = P_DATA;
            cnt_d     = '0;
            par_en_d  = PAR_EN;
            par_bit_d = (^P_DATA) ^ PAR_TYP;
        end else if (state_q == DATA) begin
            shift_d = shift_q >> 1;
            cnt_d   = (cnt_q == LAST) ? '0 : cnt_q + CW'(1);
        end
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            shift_q   <= '0;
            cnt_q     <= '0;
            par_en_q  <= 1'b0;
            par_bit_q <= 1'b0;
        end else begin
            shift_q   <= shift_d;
            cnt_q     <= cnt_d;
            par_en_q  <= par_en_d;
            par_bit_q <= par_bit_d;
        end
    end

endmodule

// File: tb/tb_uart_tx_fsm_ser.sv
// Directed self-checking bench for uart_tx_fsm_ser (DATA_WIDTH=8).
module tb_uart_tx_fsm_ser;

    logic       CLK = 1'b0;
    logic       RST = 1'b0;
    logic [7:0] P_DATA = 8'h00;
    logic       DATA_VALID = 1'b0;
    logic       PAR_EN = 1'b0;
    logic       PAR_TYP = 1'b0;
    logic [1:0] MUX_SEL;
    logic       SER_DATA;
    logic       PAR_BIT;
    logic       BUSY;

    int unsigned n_pass = 0;
    int unsigned n_total = 0;

    uart_tx_fsm_ser #(.DATA_WIDTH(8)) dut (
        .CLK(CLK), .RST(RST), .P_DATA(P_DATA), .DATA_VALID(DATA_VALID),
        .PAR_EN(PAR_EN), .PAR_TYP(PAR_TYP), .MUX_SEL(MUX_SEL),
        .SER_DATA(SER_DATA), .PAR_BIT(PAR_BIT), .BUSY(BUSY)
    );

    always #5 CLK = ~CLK;

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic test_reset();
        step();
        step();
        n_total++; if (MUX_SEL !== 2'b01) $display("FAIL reset_mux got %b want 01", MUX_SEL); else n_pass++;
        n_total++; if (BUSY !== 1'b0) $display("FAIL reset_busy got %b want 0", BUSY); else n_pass++;
        n_total++; if (SER_DATA !== 1'b0) $display("FAIL reset_ser got %b want 0", SER_DATA); else n_pass++;
        n_total++; if (PAR_BIT !== 1'b0) $display("FAIL reset_par got %b want 0", PAR_BIT); else n_pass++;
        RST = 1'b1;
        step();
        n_total++; if (BUSY !== 1'b0 || MUX_SEL !== 2'b01) $display("FAIL reset_idle got busy=%b mux=%b want 0/01", BUSY, MUX_SEL); else n_pass++;
    endtask

    // One pulse, then inputs are scrambled so the frame must rely on latched values.
    task automatic test_frame(input logic [7:0] d, input logic pe, input logic pt,
                              input logic exp_par, input string nm);
        int unsigned len;
        logic [1:0] exp_mux;
        P_DATA = d; PAR_EN = pe; PAR_TYP = pt; DATA_VALID = 1'b1;
        step();
        DATA_VALID = 1'b0; P_DATA = ~d; PAR_EN = ~pe; PAR_TYP = ~pt;
        len = 10 + (pe ? 1 : 0);
        for (int unsigned c = 0; c < len; c++) begin
            if (c > 0) step();
            if (c == 0) exp_mux = 2'b00;
            else if (c <= 8) exp_mux = 2'b10;
            else if (pe && c == 9) exp_mux = 2'b11;
            else exp_mux = 2'b01;
            n_total++; if (MUX_SEL !== exp_mux) $display("FAIL %s_mux c=%0d got %b want %b", nm, c, MUX_SEL, exp_mux); else n_pass++;
            n_total++; if (BUSY !== 1'b1) $display("FAIL %s_busy c=%0d got %b want 1", nm, c, BUSY); else n_pass++;
            n_total++; if (PAR_BIT !== exp_par) $display("FAIL %s_par c=%0d got %b want %b", nm, c, PAR_BIT, exp_par); else n_pass++;
            if (c >= 1 && c <= 8) begin
                n_total++; if (SER_DATA !== d[c-1]) $display("FAIL %s_ser bit=%0d got %b want %b", nm, c-1, SER_DATA, d[c-1]); else n_pass++;
            end
        end
        step();
        n_total++; if (BUSY !== 1'b0 || MUX_SEL !== 2'b01) $display("FAIL %s_end got busy=%b mux=%b want 0/01", nm, BUSY, MUX_SEL); else n_pass++;
    endtask

    task automatic test_back_to_back();
        logic [7:0] a, b;
        a = 8'h3C; b = 8'hC3;
        P_DATA = a; PAR_EN = 1'b0; PAR_TYP = 1'b0; DATA_VALID = 1'b1;
        step();
        n_total++; if (MUX_SEL !== 2'b00) $display("FAIL b2b_start1 got %b want 00", MUX_SEL); else n_pass++;
        P_DATA = b;
        for (int i = 0; i < 8; i++) begin
            step();
            n_total++; if (MUX_SEL !== 2'b10 || SER_DATA !== a[i]) $display("FAIL b2b_data1 bit=%0d got mux=%b ser=%b want 10/%b", i, MUX_SEL, SER_DATA, a[i]); else n_pass++;
        end
        step();
        n_total++; if (MUX_SEL !== 2'b01 || BUSY !== 1'b1) $display("FAIL b2b_stop1 got mux=%b busy=%b want 01/1", MUX_SEL, BUSY); else n_pass++;
        step();
        n_total++; if (MUX_SEL !== 2'b00 || BUSY !== 1'b1) $display("FAIL b2b_start2 got mux=%b busy=%b want 00/1", MUX_SEL, BUSY); else n_pass++;
        DATA_VALID = 1'b0;
        for (int i = 0; i < 8; i++) begin
            step();
            n_total++; if (MUX_SEL !== 2'b10 || SER_DATA !== b[i]) $display("FAIL b2b_data2 bit=%0d got mux=%b ser=%b want 10/%b", i, MUX_SEL, SER_DATA, b[i]); else n_pass++;
        end
        step();
        n_total++; if (MUX_SEL !== 2'b01 || BUSY !== 1'b1) $display("FAIL b2b_stop2 got mux=%b busy=%b want 01/1", MUX_SEL, BUSY); else n_pass++;
        step();
        n_total++; if (BUSY !== 1'b0) $display("FAIL b2b_idle got busy=%b want 0", BUSY); else n_pass++;
    endtask

    task automatic test_ignore_midframe();
        logic [7:0] a;
        a = 8'h5A;
        P_DATA = a; PAR_EN = 1'b0; PAR_TYP = 1'b1; DATA_VALID = 1'b1;
        step();
        DATA_VALID = 1'b0;
        for (int i = 0; i < 8; i++) begin
            step();
            if (i == 2) begin
                P_DATA = 8'hFF; PAR_TYP = 1'b0; DATA_VALID = 1'b1;
            end else begin
                DATA_VALID = 1'b0;
            end
            n_total++; if (MUX_SEL !== 2'b10 || SER_DATA !== a[i]) $display("FAIL ign_data bit=%0d got mux=%b ser=%b want 10/%b", i, MUX_SEL, SER_DATA, a[i]); else n_pass++;
            n_total++; if (PAR_BIT !== 1'b1) $display("FAIL ign_par bit=%0d got %b want 1", i, PAR_BIT); else n_pass++;
        end
        step();
        n_total++; if (MUX_SEL !== 2'b01 || BUSY !== 1'b1) $display("FAIL ign_stop got mux=%b busy=%b want 01/1", MUX_SEL, BUSY); else n_pass++;
        step();
        n_total++; if (BUSY !== 1'b0 || MUX_SEL !== 2'b01) $display("FAIL ign_idle got busy=%b mux=%b want 0/01", BUSY, MUX_SEL); else n_pass++;
    endtask

    task automatic test_reset_midframe();
        P_DATA = 8'hA5; PAR_EN = 1'b1; PAR_TYP = 1'b1; DATA_VALID = 1'b1;
        step();
        DATA_VALID = 1'b0;
        for (int i = 0; i < 4; i++) step();
        n_total++; if (MUX_SEL !== 2'b10 || SER_DATA !== 1'b0) $display("FAIL rstm_pre got mux=%b ser=%b want 10/0", MUX_SEL, SER_DATA); else n_pass++;
        RST = 1'b0;
        #1;
        n_total++; if (MUX_SEL !== 2'b01 || BUSY !== 1'b0) $display("FAIL rstm_now got mux=%b busy=%b want 01/0", MUX_SEL, BUSY); else n_pass++;
        n_total++; if (SER_DATA !== 1'b0 || PAR_BIT !== 1'b0) $display("FAIL rstm_dp got ser=%b par=%b want 0/0", SER_DATA, PAR_BIT); else n_pass++;
        step();
        RST = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            n_total++; if (MUX_SEL !== 2'b01 || BUSY !== 1'b0) $display("FAIL rstm_idle c=%0d got mux=%b busy=%b want 01/0", i, MUX_SEL, BUSY); else n_pass++;
        end
        P_DATA = 8'h3C; PAR_EN = 1'b0; PAR_TYP = 1'b0; DATA_VALID = 1'b1;
        step();
        DATA_VALID = 1'b0;
        n_total++; if (MUX_SEL !== 2'b00 || BUSY !== 1'b1) $display("FAIL rstm_restart got mux=%b busy=%b want 00/1", MUX_SEL, BUSY); else n_pass++;
        for (int i = 0; i < 10; i++) step();
        n_total++; if (BUSY !== 1'b0) $display("FAIL rstm_end got busy=%b want 0", BUSY); else n_pass++;
    endtask

`ifdef UART_TX_TWO_STOP_EN
    task automatic test_two_stop();
        P_DATA = 8'h81; PAR_EN = 1'b0; PAR_TYP = 1'b0; DATA_VALID = 1'b1;
        step();
        DATA_VALID = 1'b0;
        for (int i = 0; i < 9; i++) step();
        n_total++; if (MUX_SEL !== 2'b01 || BUSY !== 1'b1) $display("FAIL two_stop1 got mux=%b busy=%b want 01/1", MUX_SEL, BUSY); else n_pass++;
        P_DATA = 8'hFF; DATA_VALID = 1'b1;
        step();
        DATA_VALID = 1'b0;
        n_total++; if (MUX_SEL !== 2'b01 || BUSY !== 1'b1) $display("FAIL two_stop2 got mux=%b busy=%b want 01/1", MUX_SEL, BUSY); else n_pass++;
        step();
        n_total++; if (MUX_SEL !== 2'b01 || BUSY !== 1'b0) $display("FAIL two_idle got mux=%b busy=%b want 01/0", MUX_SEL, BUSY); else n_pass++;
    endtask
`endif

    initial begin
        test_reset();
        test_frame(8'hA5, 1'b1, 1'b0, 1'b0, "even");
        test_frame(8'hA5, 1'b1, 1'b1, 1'b1, "odd");
        test_frame(8'h00, 1'b0, 1'b1, 1'b1, "nopar");
        test_back_to_back();
        test_ignore_midframe();
        test_reset_midframe();
`ifdef UART_TX_TWO_STOP_EN
        test_two_stop();
`endif
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
